// File: rtl/vga_timing_gen.sv
// vga_timing_gen -- free-running VGA raster timing generator.
//
// Produces the pixel position and the sync/blank strobes for a raster whose
// geometry is set by the H_*/V_* parameters (defaults: 640x480 @ 800x525).
// Every output is a flop, and sync/blank are computed from the same "next"
// position that is loaded into DrawX/DrawY. That way the strobes seen in a
// cycle always describe the position seen in that same cycle.
//
// Ports:
//   pixel_clk    in   pixel clock
//   Reset        in   asynchronous, active-high reset
//   hs           out  horizontal sync, active low
//   vs           out  vertical sync, active low
//   blank        out  1 = active video, 0 = blanking
//   DrawX        out  horizontal position, 0..H_TOTAL-1
//   DrawY        out  vertical position, 0..V_TOTAL-1
//   frame_start  out  one-cycle pulse when the raster wraps back to (0,0)
//   frame_count  out  frames completed since reset, wraps at 16 bits
module vga_timing_gen #(
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33
) (
    input  logic        pixel_clk,
    input  logic        Reset,
    output logic        hs,
    output logic        vs,
    output logic        blank,
    output logic [9:0]  DrawX,
    output logic [9:0]  DrawY,
    output logic        frame_start,
    output logic [15:0] frame_count
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    // The position counters are 10 bits wide, so neither total may exceed 1024.
    if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : gBadTiming
        $error("vga_timing_gen: H_TOTAL and V_TOTAL must be <= 1024");
    end

    // The window limits are kept at 11 bits. A limit equal to 1024 then does
    // not alias to 0.
    localparam logic [10:0] H_LAST     = 11'(H_TOTAL - 1);
    localparam logic [10:0] V_LAST     = 11'(V_TOTAL - 1);
    localparam logic [10:0] H_ACT      = 11'(H_VISIBLE);
    localparam logic [10:0] V_ACT      = 11'(V_VISIBLE);
    localparam logic [10:0] HS_START   = 11'(H_VISIBLE + H_FRONT);
    localparam logic [10:0] HS_END     = 11'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [10:0] VS_START   = 11'(V_VISIBLE + V_FRONT);
    localparam logic [10:0] VS_END     = 11'(V_VISIBLE + V_FRONT + V_SYNC);

    logic        lineEnd;
    logic        frameEnd;
    logic [9:0]  xNext;
    logic [9:0]  yNext;
    logic [10:0] xWide;
    logic [10:0] yWide;

    assign lineEnd  = ({1'b0, DrawX} == H_LAST);
    assign frameEnd = lineEnd && ({1'b0, DrawY} == V_LAST);

    always_comb begin
        xNext = DrawX + 10'd1;
        yNext = DrawY;
        if (lineEnd) begin
            xNext = '0;
            yNext = frameEnd ? '0 : DrawY + 10'd1;
        end
    end

    assign xWide = {1'b0, xNext};
    assign yWide = {1'b0, yNext};

    always_ff @(posedge pixel_clk or posedge Reset) begin
        if (Reset) begin
            DrawX       <= '0;
            DrawY       <= '0;
            hs          <= 1'b1;
            vs          <= 1'b1;
            blank       <= 1'b1;
            frame_start <= 1'b0;
            frame_count <= '0;
        end else begin
            DrawX       <= xNext;
            DrawY       <= yNext;
            // Strobes are decoded from the next position so they line up with it.
            hs          <= !(xWide >= HS_START && xWide < HS_END);
            vs          <= !(yWide >= VS_START && yWide < VS_END);
            blank       <= (xWide < H_ACT) && (yWide < V_ACT);
            // The (H_LAST,V_LAST) -> (0,0) wrap is the only source of the pulse.
            // The reset-held (0,0) is therefore never flagged.
            frame_start <= frameEnd;
            if (frameEnd) begin
                frame_count <= frame_count + 16'd1;
            end
        end
    end

endmodule
